// File: rtl/core_alu_issue.sv
// Two-stage ALU issue/result pipe: S1 holds operands for an external ALU,
// S2 holds the result until the writeback consumer accepts it.
module core_alu_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_valid,
    output logic        dec_ready,
    input  logic [31:0] dec_rs1,
    input  logic [31:0] dec_rs2,
    input  logic [31:0] dec_imm,
    input  logic [31:0] dec_pc,
    input  logic        dec_op1_pc,
    input  logic        dec_op2_imm,
    input  logic [3:0]  dec_func,
    input  logic [4:0]  dec_rd,
    input  logic        dec_rd_we,
    input  logic        flush,
    output logic        alu_eval_en,
    output logic [31:0] alu_opnum1,
    output logic [31:0] alu_opnum2,
    output logic [3:0]  alu_func,
    input  logic [31:0] alu_res,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_we,
    output logic [31:0] retire_cnt
);

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [3:0]  func;
        logic [4:0]  rd;
        logic        we;
    } s1_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        we;
    } s2_t;

    logic s1_valid, s2_valid;
    logic s1_adv, accept;
    s1_t  s1;
    s2_t  s2;

    assign s1_adv    = s1_valid && (!s2_valid || wb_ready);
    assign dec_ready = !flush && (!s1_valid || s1_adv);
    assign accept    = dec_valid && dec_ready;

    assign alu_eval_en = s1_valid;
    assign alu_opnum1  = s1_valid ? s1.op1  : 32'd0;
    assign alu_opnum2  = s1_valid ? s1.op2  : 32'd0;
    assign alu_func    = s1_valid ? s1.func : 4'd0;

    assign wb_valid = s2_valid;
    assign wb_data  = s2.data;
    assign wb_rd    = s2.rd;
    assign wb_we    = s2_valid && s2.we;

    // Flush wins over both accept and advance; a handshake in the same cycle still retires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (accept)      s1_valid <= 1'b1;
            else if (s1_adv) s1_valid <= 1'b0;

            if (s1_adv)        s2_valid <= 1'b1;
            else if (wb_ready) s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
        end else if (accept) begin
            s1.op1  <= dec_op1_pc  ? dec_pc  : dec_rs1;
            s1.op2  <= dec_op2_imm ? dec_imm : dec_rs2;
            s1.func <= dec_func;
            s1.rd   <= dec_rd;
            s1.we   <= dec_rd_we && (dec_rd != 5'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2 <= '0;
        end else if (s1_adv && !flush) begin
            s2.data <= alu_res;
            s2.rd   <= s1.rd;
            s2.we   <= s1.we;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   retire_cnt <= 32'd0;
        else if (wb_valid && wb_ready) retire_cnt <= retire_cnt + 32'd1;
    end

endmodule

// File: doc/core_alu_issue.md
CORE_ALU_ISSUE -- requirements
Module: core_alu_issue

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 dec_valid  input  1  decode offers an ALU op this cycle.
REQ-005 dec_ready  output  1  block accepts the op this cycle.
REQ-006 dec_rs1, dec_rs2, dec_imm, dec_pc  input  32 each  rs1 data, rs2 data, sign-extended immediate, instruction PC.
REQ-007 dec_op1_pc  input  1  operand 1 is dec_pc when 1, dec_rs1 when 0.
REQ-008 dec_op2_imm  input  1  operand 2 is dec_imm when 1, dec_rs2 when 0.
REQ-009 dec_func  input  4  ALU function code from the core ALU function define set.
REQ-010 dec_rd  input  5  destination register; dec_rd_we  input  1  writeback enable.
REQ-011 flush  input  1  discards all in-flight ops.
REQ-012 alu_eval_en  output  1  ALU evaluate enable.
REQ-013 alu_opnum1, alu_opnum2  output  32 each  ALU operands.
REQ-014 alu_func  output  4  ALU function select.
REQ-015 alu_res  input  32  combinational ALU result for the current outputs.
REQ-016 wb_valid  output  1  result is available; wb_ready  input  1  writeback consumer accepts.
REQ-017 wb_data  output  32, wb_rd  output  5, wb_we  output  1  writeback payload.
REQ-018 retire_cnt  output  32  count of completed writeback handshakes.

Function
REQ-019 Two register stages SHALL be used: S1 (issue) and S2 (result), each with its own valid bit.
REQ-020 Accept condition: dec_valid && dec_ready && !flush.
REQ-021 dec_ready SHALL equal !flush && (!s1_valid || s1_adv), with s1_adv = s1_valid && (!s2_valid || wb_ready).
REQ-022 On accept, S1 SHALL capture the muxed operand 1 (per REQ-007), the muxed operand 2 (per REQ-008), dec_func, dec_rd, and dec_rd_we && (dec_rd != 0).
REQ-023 alu_eval_en SHALL equal s1_valid; alu_opnum1/alu_opnum2/alu_func SHALL be driven directly from S1 registers, all zero when !s1_valid.
REQ-024 On s1_adv, S2 SHALL capture alu_res, rd, and we from S1; s2_valid SHALL be set.
REQ-025 S1 valid next state: 1 on accept; else 0 if s1_adv; else hold. Simultaneous accept and advance keeps S1 full with the new op.
REQ-026 S2 valid next state: 1 if s1_adv; else 0 if wb_ready; else hold.
REQ-027 wb_valid = s2_valid; wb_data/wb_rd/wb_we SHALL come from S2. wb_we SHALL be 0 when !s2_valid.
REQ-028 Latency: accept at edge N -> wb_valid high after edge N+1 with no backpressure; throughput one op per cycle.
REQ-029 While wb_valid && !wb_ready, S2 payload SHALL remain stable; S1 SHALL hold; dec_ready SHALL be low if S1 is full.
REQ-030 flush SHALL clear s1_valid and s2_valid at the next edge, overriding accept and advance; retire_cnt SHALL still count a handshake completing in the flush cycle.
REQ-031 retire_cnt SHALL increment by 1 on each wb_valid && wb_ready edge, wrapping from 0xFFFFFFFF to 0.

Reset
REQ-032 While rst_n is low, s1_valid, s2_valid, all S1/S2 payload registers, and retire_cnt SHALL be 0 asynchronously.
REQ-033 During reset, alu_eval_en, wb_valid, and wb_we SHALL be 0 and dec_ready SHALL be 1 (flush low).
REQ-034 Reset asserted mid-operation SHALL discard all in-flight ops with no writeback produced.

Verification
REQ-035 Single op: rs1=5, imm=7, op2_imm=1, func=ADD, rd=3, wb_ready=1 -> one cycle later wb_valid=1, wb_data=12, wb_rd=3, wb_we=1; retire_cnt=1.
REQ-036 Backpressure: three back-to-back SUB ops with wb_ready=0 -> S2 holds the first result stable, dec_ready drops after the second accept; after wb_ready=1, results are in order with none lost.
REQ-037 rd=0 with rd_we=1, op1_pc=1, pc=0x100, imm=4, ADD -> wb_data=0x104, wb_we=0.
REQ-038 Flush with S1 and S2 full and dec_valid=1 -> next cycle wb_valid=0, alu_eval_en=0, and nothing is accepted.
REQ-039 Preload retire_cnt near wrap via 2^32-1 handshakes (or force) -> one more handshake gives retire_cnt=0.
REQ-040 Assert rst_n=0 asynchronously between edges with both stages full -> outputs go to reset values immediately; no writeback occurs after release.
